insn_decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Decodes every base opcode into

---
 rtl/riscv_decode_pkg.sv | 69 ++++++
 rtl/insn_decode_logic.sv | 120 ++++++++++++
 rtl/insn_decode_stage.sv | 125 ++++++++++++
 tb/tb_insn_decode_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU encoding, immediate formats and the
// decoded bundle handed from decode to execute.
package riscv_decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        alu_op_e         alu_op;
        logic            alu_src_imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic [2:0]      mem_size;
        logic            branch;
        logic            jump;
        logic            illegal;
    } decoded_t;

    // Immediates are assembled at 32 bits, then sign-extended to the datapath width.
    function automatic logic [XLEN-1:0] make_imm(input imm_fmt_e fmt, input logic [31:0] insn);
        logic signed [31:0] v;
        case (fmt)
            IMM_I:   v = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   v = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   v = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   v = {insn[31:12], 12'h000};
            IMM_J:   v = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: v = 32'sd0;
        endcase
        return XLEN'(v);
    endfunction

endpackage

// File: rtl/insn_decode_logic.sv
// Purely combinational RV32I decoder: one instruction word in, one decoded bundle out.
module insn_decode_logic
    import riscv_decode_pkg::*;
#(
    parameter bit ZERO_RD_WE = 1'b1
) (
    input  logic [31:0] insn,
    output decoded_t    dec
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       legal_s;
    logic       zero_rd_s;
    imm_fmt_e   fmt_s;
    decoded_t   dec_s;

    assign opcode_s = insn[6:0];
    assign funct3_s = insn[14:12];
    assign funct7_s = insn[31:25];

    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Field extraction, legality check and control generation per opcode.
    always_comb begin
        dec_s        = '0;
        dec_s.alu_op = ALU_ADD;
        fmt_s        = IMM_NONE;
        legal_s      = 1'b1;
        case (opcode_s)
            OPC_LOAD: begin
                fmt_s = IMM_I; dec_s.rd = insn[11:7]; dec_s.rs1 = insn[19:15];
                dec_s.alu_src_imm = 1'b1; dec_s.reg_we = 1'b1; dec_s.mem_re = 1'b1;
                dec_s.mem_size = funct3_s;
                legal_s = (funct3_s != 3'b011) && (funct3_s != 3'b110) && (funct3_s != 3'b111);
            end
            OPC_STORE: begin
                fmt_s = IMM_S; dec_s.rs1 = insn[19:15]; dec_s.rs2 = insn[24:20];
                dec_s.alu_src_imm = 1'b1; dec_s.mem_we = 1'b1; dec_s.mem_size = funct3_s;
                legal_s = (funct3_s[2] == 1'b0) && (funct3_s[1:0] != 2'b11);
            end
            OPC_OPIMM: begin
                fmt_s = IMM_I; dec_s.rd = insn[11:7]; dec_s.rs1 = insn[19:15];
                dec_s.alu_src_imm = 1'b1; dec_s.reg_we = 1'b1;
                // Only the right shift uses funct7[5]; ADDI has no SUB form.
                dec_s.alu_op = alu_from_f3(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
                if (funct3_s == 3'b001) begin
                    legal_s = (funct7_s == 7'b0000000);
                end else if (funct3_s == 3'b101) begin
                    legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_OP: begin
                dec_s.rd = insn[11:7]; dec_s.rs1 = insn[19:15]; dec_s.rs2 = insn[24:20];
                dec_s.reg_we = 1'b1;
                dec_s.alu_op = alu_from_f3(funct3_s, funct7_s[5]);
                legal_s = (funct7_s == 7'b0000000) ||
                          ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            end
            OPC_BRANCH: begin
                fmt_s = IMM_B; dec_s.rs1 = insn[19:15]; dec_s.rs2 = insn[24:20];
                dec_s.branch = 1'b1; dec_s.alu_op = ALU_SUB;
                legal_s = (funct3_s[2:1] != 2'b01);
            end
            OPC_JAL: begin
                fmt_s = IMM_J; dec_s.rd = insn[11:7];
                dec_s.alu_src_imm = 1'b1; dec_s.reg_we = 1'b1; dec_s.jump = 1'b1;
            end
            OPC_JALR: begin
                fmt_s = IMM_I; dec_s.rd = insn[11:7]; dec_s.rs1 = insn[19:15];
                dec_s.alu_src_imm = 1'b1; dec_s.reg_we = 1'b1; dec_s.jump = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_s = IMM_U; dec_s.rd = insn[11:7];
                dec_s.alu_src_imm = 1'b1; dec_s.reg_we = 1'b1;
            end
            default: begin
                // Unknown opcodes keep R-type register fields so the trap handler sees them.
                legal_s = 1'b0;
                dec_s.rd = insn[11:7]; dec_s.rs1 = insn[19:15]; dec_s.rs2 = insn[24:20];
            end
        endcase

        dec_s.imm = make_imm(fmt_s, insn);

        if (!legal_s) begin
            dec_s.illegal     = 1'b1;
            dec_s.reg_we      = 1'b0;
            dec_s.mem_re      = 1'b0;
            dec_s.mem_we      = 1'b0;
            dec_s.branch      = 1'b0;
            dec_s.jump        = 1'b0;
            dec_s.alu_op      = ALU_ADD;
            dec_s.alu_src_imm = 1'b0;
            dec_s.mem_size    = 3'b000;
        end else begin
            dec_s.illegal     = 1'b0;
        end

        zero_rd_s    = ZERO_RD_WE && (dec_s.rd == 5'd0);
        dec_s.reg_we = dec_s.reg_we && !zero_rd_s;
    end

    assign dec = dec_s;

endmodule

// File: rtl/insn_decode_stage.sv
// Registered RV32I decode stage: decodes on entry and buffers bundles in a small
// circular queue between valid/ready fetch and execute interfaces.
module insn_decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int XLEN       = riscv_decode_pkg::XLEN,
    parameter int DEPTH      = 2,
    parameter bit ZERO_RD_WE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_src_imm,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [2:0]      out_mem_size,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_t         dec_s;
    entry_t           queue_r [DEPTH];
    entry_t           head_s;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             not_empty_s;

    insn_decode_logic #(.ZERO_RD_WE(ZERO_RD_WE)) u_decode (
        .insn (in_insn),
        .dec  (dec_s)
    );

    // Ready depends only on the occupancy register, never on out_ready.
    assign in_ready_s  = (count_r < DEPTH_C);
    assign not_empty_s = (count_r != CNT_ZERO);
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = not_empty_s && out_ready;

    // Queue pointers and occupancy; reset beats flush, flush beats any handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count_r  <= CNT_ZERO;
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Bundle storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !rst) begin
            queue_r[wr_ptr_r] <= {in_pc, dec_s};
        end
    end

    // Head view is zeroed whenever the queue is empty.
    always_comb begin
        head_s = '0;
        if (not_empty_s) begin
            head_s = queue_r[rd_ptr_r];
        end else begin
            head_s = '0;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = not_empty_s;
    assign out_pc          = head_s.pc;
    assign out_rs1         = head_s.dec.rs1;
    assign out_rs2         = head_s.dec.rs2;
    assign out_rd          = head_s.dec.rd;
    assign out_imm         = head_s.dec.imm;
    assign out_alu_op      = head_s.dec.alu_op;
    assign out_alu_src_imm = head_s.dec.alu_src_imm;
    assign out_reg_we      = head_s.dec.reg_we;
    assign out_mem_re      = head_s.dec.mem_re;
    assign out_mem_we      = head_s.dec.mem_we;
    assign out_mem_size    = head_s.dec.mem_size;
    assign out_branch      = head_s.dec.branch;
    assign out_jump        = head_s.dec.jump;
    assign out_illegal     = head_s.dec.illegal;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Bench for insn_decode_stage: directed cases with literal expectations plus a random
// stream compared every cycle against a queue-based behavioural model.
module tb_insn_decode_stage;
    import riscv_decode_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] ADDI_X1 = 32'h00100093;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src, we, re, mwe;
        logic [2:0]  size;
        logic        br, j, ill;
    } exp_t;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_insn, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_mem_size;
    logic        out_alu_src_imm, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump, out_illegal;
    logic [92:0] act_s;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 1'b0;
    exp_t mq [$];

    insn_decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ZERO_RD_WE(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_op(out_alu_op), .out_alu_src_imm(out_alu_src_imm), .out_reg_we(out_reg_we),
        .out_mem_re(out_mem_re), .out_mem_we(out_mem_we), .out_mem_size(out_mem_size),
        .out_branch(out_branch), .out_jump(out_jump), .out_illegal(out_illegal)
    );

    assign act_s = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op, out_alu_src_imm,
                    out_reg_we, out_mem_re, out_mem_we, out_mem_size, out_branch, out_jump, out_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA's field layout and legality rules.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        logic [3:0]  tbl [8];
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        ok;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        f7 = w[31:25];
        f3 = w[14:12];
        i_imm = 32'($signed(w) >>> 20);
        s_imm = (i_imm & ~32'h1F) | ((w >> 7) & 32'h1F);
        b_imm = (s_imm & ~32'h801) | ({31'd0, w[7]} << 11);
        u_imm = w & 32'hFFFFF000;
        j_imm = (32'($signed(w) >>> 11) & 32'hFFF00000) | (w & 32'h000FF000) |
                ({31'd0, w[20]} << 11) | ((w >> 20) & 32'h7FE);
        e = '0;
        e.pc = pc;
        ok = 1'b1;
        case (w[6:0])
            OPC_LOAD: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm;
                e.src = 1'b1; e.we = 1'b1; e.re = 1'b1; e.size = f3;
            end
            OPC_STORE: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2};
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = s_imm;
                e.src = 1'b1; e.mwe = 1'b1; e.size = f3;
            end
            OPC_OPIMM: begin
                ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.src = 1'b1; e.we = 1'b1;
                e.alu = tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) e.alu = ALU_SRA;
            end
            OPC_OP: begin
                ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.we = 1'b1;
                e.alu = tbl[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
                if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
            end
            OPC_BRANCH: begin
                ok = !(f3 == 3'd2 || f3 == 3'd3);
                e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = b_imm; e.br = 1'b1; e.alu = ALU_SUB;
            end
            OPC_JAL: begin
                e.rd = w[11:7]; e.imm = j_imm; e.src = 1'b1; e.we = 1'b1; e.j = 1'b1;
            end
            OPC_JALR: begin
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = i_imm; e.src = 1'b1; e.we = 1'b1; e.j = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                e.rd = w[11:7]; e.imm = u_imm; e.src = 1'b1; e.we = 1'b1;
            end
            default: begin
                ok = 1'b0;
                e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            end
        endcase
        if (!ok) begin
            e.ill = 1'b1; e.we = 1'b0; e.re = 1'b0; e.mwe = 1'b0; e.br = 1'b0; e.j = 1'b0;
            e.alu = ALU_ADD; e.src = 1'b0; e.size = 3'd0;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    // Every cycle: handshake outputs and head bundle against the model queue.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 96'(in_ready), 96'(mq.size() < DEPTH));
            check("out_valid", 96'(out_valid), 96'(mq.size() != 0));
            if (mq.size() != 0) check("head_bundle", 96'(act_s), 96'(mq[0]));
            else                check("idle_zero", 96'(act_s), 96'(0));
        end
    end

    // One cycle: drive at negedge, update model at the edge, return at next negedge.
    task automatic cyc(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        logic acc, pp;
        exp_t e, tmp;
        in_valid = v; in_insn = insn; in_pc = pc; out_ready = ordy; flush = fl;
        acc = v && (mq.size() < DEPTH);
        pp  = (mq.size() != 0) && ordy;
        e   = model(insn, pc);
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (pp) tmp = mq.pop_front();
            if (acc) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  opcs [9];
        logic [31:0] r;
        opcs = '{OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = 32'd0; in_pc = 32'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 96'(out_valid), 96'(0));
        check("reset_in_ready", 96'(in_ready), 96'(1));
        check("reset_fields", 96'(act_s), 96'(0));
        rst = 1'b0;
        chk_en = 1'b1;

        // lw x5,8(x2)
        cyc(1'b1, 32'h00812283, 32'h100, 1'b1, 1'b0);
        check("lw_valid", 96'(out_valid), 96'(1));
        check("lw_rd", 96'(out_rd), 96'(5));
        check("lw_rs1", 96'(out_rs1), 96'(2));
        check("lw_imm", 96'(out_imm), 96'(8));
        check("lw_ctl", 96'({out_reg_we, out_mem_re, out_mem_size, out_illegal}), 96'(6'b11_010_0));
        // sw x6,-4(x2)
        cyc(1'b1, 32'hFE612E23, 32'h104, 1'b1, 1'b0);
        check("sw_ctl", 96'({out_mem_we, out_reg_we, out_mem_size}), 96'(5'b10_010));
        check("sw_regs", 96'({out_rs1, out_rs2}), 96'({5'd2, 5'd6}));
        check("sw_imm", 96'(out_imm), 96'(32'hFFFFFFFC));
        cyc(1'b1, 32'h00000013, 32'h108, 1'b1, 1'b0);
        check("nop_ctl", 96'({out_reg_we, out_illegal}), 96'(2'b00));
        cyc(1'b1, 32'h00000000, 32'h10C, 1'b1, 1'b0);
        check("zero_ctl", 96'({out_illegal, out_reg_we, out_mem_re, out_mem_we, out_branch, out_jump}),
              96'(6'b100000));
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Back-pressure with a two-entry queue
        cyc(1'b1, ADDI_X1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, ADDI_X1, 32'h4, 1'b0, 1'b0);
        check("full_in_ready", 96'(in_ready), 96'(0));
        check("full_head_pc", 96'(out_pc), 96'(32'h0));
        cyc(1'b1, ADDI_X1, 32'h8, 1'b1, 1'b0);
        check("drain1_pc", 96'(out_pc), 96'(32'h4));
        check("drain1_ready", 96'(in_ready), 96'(1));
        cyc(1'b1, ADDI_X1, 32'h8, 1'b1, 1'b0);
        check("drain2_pc", 96'(out_pc), 96'(32'h8));
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("drained", 96'(out_valid), 96'(0));

        // Flush with two queued and a concurrent push
        cyc(1'b1, ADDI_X1, 32'h20, 1'b0, 1'b0);
        cyc(1'b1, ADDI_X1, 32'h24, 1'b0, 1'b0);
        cyc(1'b1, ADDI_X1, 32'h40, 1'b0, 1'b1);
        check("flush_valid", 96'({out_valid, in_ready}), 96'(2'b01));
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush_gone", 96'(out_valid), 96'(0));

        // Random stream with back-pressure, flushes and occasional mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = opcs[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 3) != 0), r, ($urandom & 32'hFFFFFFFC),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
